// File: rtl/fp_pkg.sv
// Shared constants for the bit-serial subtractor in the floating-point datapath.
package fp_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    NEG  = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and result bundle for serial_subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = fp_pkg::DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic [WIDTH-1:0] mag;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, mag
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, mag
  );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, bout = borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, borrow = a < b, mag = |a - b|.
// state | meaning
// IDLE  | waiting for start, results held
// SUB   | one bit of a - b per cycle, LSB first
// NEG   | one bit of 0 - diff per cycle when a < b
// FIN   | results valid, done pulse
module serial_subtractor
  import fp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic               clk,
  input logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr, b_sr, diff_sr, mag_sr;
  logic [WIDTH-1:0] diff_q, mag_q;
  logic             bflop, borrow_q, busy_q, done_q;
  logic             busy_nxt, done_nxt;
  logic             fs_x, fs_y, fs_d, fs_bout;
  logic             last;
  logic [WIDTH-1:0] shifted_diff, shifted_mag;

  assign last         = (cnt == CW'(WIDTH - 1));
  assign shifted_diff = {fs_d, diff_sr[WIDTH-1:1]};
  assign shifted_mag  = {fs_d, mag_sr[WIDTH-1:1]};

  // In NEG the a shift register carries diff, so the cell computes 0 - diff.
  always_comb begin
    fs_x = a_sr[0];
    fs_y = b_sr[0];
    if (state == NEG) begin
      fs_x = 1'b0;
      fs_y = a_sr[0];
    end
  end

  full_subtractor u_fs (
    .x    (fs_x),
    .y    (fs_y),
    .bin  (bflop),
    .d    (fs_d),
    .bout (fs_bout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = SUB;
      SUB:  if (last) state_nxt = fs_bout ? NEG : FIN;
      NEG:  if (last) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_nxt = (state_nxt == SUB) || (state_nxt == NEG);
    done_nxt = (state_nxt == FIN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_nxt;
      done_q <= done_nxt;
    end
  end

  // Result registers load on the edge entering FIN so they are valid with done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      diff_sr  <= '0;
      mag_sr   <= '0;
      cnt      <= '0;
      bflop    <= 1'b0;
      diff_q   <= '0;
      mag_q    <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr    <= bus.a;
            b_sr    <= bus.b;
            diff_sr <= '0;
            mag_sr  <= '0;
            cnt     <= '0;
            bflop   <= 1'b0;
          end
        end
        SUB: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          diff_sr <= shifted_diff;
          bflop   <= fs_bout;
          cnt     <= cnt + 1'b1;
          if (last) begin
            cnt <= '0;
            if (fs_bout) begin
              a_sr  <= shifted_diff;
              bflop <= 1'b0;
            end else begin
              mag_sr   <= shifted_diff;
              diff_q   <= shifted_diff;
              mag_q    <= shifted_diff;
              borrow_q <= 1'b0;
            end
          end
        end
        NEG: begin
          a_sr   <= a_sr >> 1;
          mag_sr <= shifted_mag;
          bflop  <= fs_bout;
          cnt    <= cnt + 1'b1;
          if (last) begin
            cnt      <= '0;
            diff_q   <= diff_sr;
            mag_q    <= shifted_mag;
            borrow_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
  assign bus.mag    = mag_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: latency, busy window, results, abort by reset.
module tb_serial_subtractor;
  import fp_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         borrow;
    logic [W-1:0] mag;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    int   lat;
    bit   busy_bad;
    e.borrow = (av < bv);
    e.diff   = av - bv;
    e.mag    = e.borrow ? (bv - av) : (av - bv);
    e.lat    = e.borrow ? 2 * W + 1 : W + 1;
    sb.push_back(e);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL idle_before_start a=%h b=%h: busy=%b done=%b, required 0/0", av, bv, bus.busy, bus.done);
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) errors++;
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    lat      = 0;
    busy_bad = 1'b0;
    for (int k = 1; k <= 3 * W + 5; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = k;
        if (bus.busy !== 1'b0) busy_bad = 1'b1;
        break;
      end
      if (bus.busy !== 1'b1) busy_bad = 1'b1;
    end
    e = sb.pop_front();
    checks++;
    if (lat != e.lat) begin
      errors++;
      $display("FAIL latency a=%h b=%h: done at cycle %0d (0=timeout), required %0d", av, bv, lat, e.lat);
    end
    checks++;
    if (busy_bad) begin
      errors++;
      $display("FAIL busy_window a=%h b=%h: busy not high exactly until done", av, bv);
    end
    checks++;
    if (bus.diff !== e.diff) begin
      errors++;
      $display("FAIL diff a=%h b=%h: got %h, required %h", av, bv, bus.diff, e.diff);
    end
    checks++;
    if (bus.borrow !== e.borrow) begin
      errors++;
      $display("FAIL borrow a=%h b=%h: got %b, required %b", av, bv, bus.borrow, e.borrow);
    end
    checks++;
    if (bus.mag !== e.mag) begin
      errors++;
      $display("FAIL mag a=%h b=%h: got %h, required %h", av, bv, bus.mag, e.mag);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.borrow, bus.diff, bus.mag} !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b borrow=%b diff=%h mag=%h, required all 0",
               bus.busy, bus.done, bus.borrow, bus.diff, bus.mag);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [6] = '{8'h2A, 8'h0F, 8'h55, 8'h00, 8'h00, 8'hFF};
    logic [W-1:0] vb [6] = '{8'h0F, 8'h2A, 8'h55, 8'hFF, 8'h80, 8'h00};
    for (int i = 0; i < 6; i++) run_op(va[i], vb[i]);
  endtask

  task automatic test_back_to_back();
    run_op(8'h81, 8'h7F);
    run_op(8'h7F, 8'h81);
    run_op(8'h01, 8'h02);
  endtask

  task automatic test_abort();
    int done_seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h10;
    bus.b     = 8'h20;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'hAA;
    bus.b     = 8'h01;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL abort_ignore_start: busy=%b done=%b, required 1/0", bus.busy, bus.done);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({bus.busy, bus.done, bus.borrow, bus.diff, bus.mag} !== '0) begin
      errors++;
      $display("FAIL abort_reset_state: busy=%b done=%b borrow=%b diff=%h mag=%h, required all 0",
               bus.busy, bus.done, bus.borrow, bus.diff, bus.mag);
    end
    done_seen = 0;
    for (int k = 0; k < 2 * W + 4; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL abort_no_done: busy/done seen in %0d cycles, required 0", done_seen);
    end
    run_op(8'h09, 8'h04);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) run_op(W'($urandom), W'($urandom));
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
